// File: rtl/inst_fifo_pkg.sv
// ----------------------------------------------------------------------------
// inst_fifo_pkg
//   Shared types and constants for the fetch -> issue instruction queue.
//   pipe_entry_t : one fetched instruction (pc + raw instruction word)
//   fifo_ctrl_t  : occupancy flags the issue logic uses to gate dual issue
// ----------------------------------------------------------------------------
package inst_fifo_pkg;

    localparam int ISSUE_NUM       = 2;
    localparam int INST_FIFO_DEPTH = 16;
    localparam int XLEN            = 64;
    localparam int ILEN            = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } pipe_entry_t;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic full;
        logic almost_full;
    } fifo_ctrl_t;

endpackage : inst_fifo_pkg

// File: rtl/inst_fifo_ram.sv
// ----------------------------------------------------------------------------
// inst_fifo_ram
//   DEPTH x pipe_entry_t storage with two independent write ports and two
//   asynchronous read ports.
//   Ports:
//     clk              rising-edge clock
//     we0/waddr0/wdata0  write port 0
//     we1/waddr1/wdata1  write port 1 (addresses never collide with port 0)
//     raddr0/rdata0      async read port 0
//     raddr1/rdata1      async read port 1
// ----------------------------------------------------------------------------
module inst_fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we0,
    input  logic [PTR_W-1:0]  waddr0,
    input  pipe_entry_t       wdata0,
    input  logic              we1,
    input  logic [PTR_W-1:0]  waddr1,
    input  pipe_entry_t       wdata1,
    input  logic [PTR_W-1:0]  raddr0,
    output pipe_entry_t       rdata0,
    input  logic [PTR_W-1:0]  raddr1,
    output pipe_entry_t       rdata1
);

    pipe_entry_t mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked by the pointers and
    // count, so clearing the array would only cost area and reset fanout.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule : inst_fifo_ram

// File: rtl/inst_fifo.sv
// ----------------------------------------------------------------------------
// inst_fifo
//   Dual-port instruction queue between fetch and decode/issue. Fetch pushes
//   0-2 entries per cycle, issue pops 0-2 entries per cycle from the head.
//   Ports:
//     clk          rising-edge clock
//     resetn       synchronous active-low reset
//     flush        redirect: discard every entry (wins over push/pop)
//     fetch_valid  per-slot push request, slot0 is older
//     fetch_entry  pc/instr per slot
//     fetch_ready  room for two entries this cycle (pre-pop occupancy)
//     issue_en     pop request; [1] only counts together with [0]
//     id_pipe      head entry and head+1 entry
//     id_valid     id_pipe slot holds a real entry
//     fifo_ctrl    {empty, almost_empty, full, almost_full}
// ----------------------------------------------------------------------------
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic        [ISSUE_NUM-1:0]  fetch_valid,
    input  pipe_entry_t [ISSUE_NUM-1:0]  fetch_entry,
    output logic                         fetch_ready,
    input  logic        [ISSUE_NUM-1:0]  issue_en,
    output pipe_entry_t [ISSUE_NUM-1:0]  id_pipe,
    output logic        [ISSUE_NUM-1:0]  id_valid,
    output fifo_ctrl_t                   fifo_ctrl
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t rptr_q, rptr_d;
    ptr_t wptr_q, wptr_d;
    cnt_t count_q, count_d;

    logic [1:0] n_pop_req;
    logic [1:0] n_pop;
    logic [1:0] n_push;
    logic       push_ok;

    logic        we0, we1;
    ptr_t        waddr1;
    pipe_entry_t wdata0;

    // ------------------------------------------------------------------
    // Flags and readiness come only from the registered count.
    // ------------------------------------------------------------------
    assign fetch_ready = (count_q <= cnt_t'(DEPTH - 2));

    assign fifo_ctrl = '{
        empty:        (count_q == cnt_t'(0)),
        almost_empty: (count_q == cnt_t'(1)),
        full:         (count_q == cnt_t'(DEPTH)),
        almost_full:  (count_q == cnt_t'(DEPTH - 1))
    };

    assign id_valid[0] = (count_q >= cnt_t'(1));
    assign id_valid[1] = (count_q >= cnt_t'(2));

    // ------------------------------------------------------------------
    // Pop/push sizing. Slot1 of issue_en only pops behind slot0, and a pop
    // never takes more than what is held.
    // ------------------------------------------------------------------
    assign n_pop_req = {1'b0, issue_en[0]} + {1'b0, issue_en[0] & issue_en[1]};
    assign n_pop     = (cnt_t'(n_pop_req) > count_q) ? count_q[1:0] : n_pop_req;

    assign push_ok = fetch_ready && !flush;
    assign n_push  = push_ok ? ({1'b0, fetch_valid[0]} + {1'b0, fetch_valid[1]}) : 2'd0;

    // Valid slots are compacted: a lone slot1 lands at wptr just like slot0.
    assign we0    = push_ok && (|fetch_valid);
    assign we1    = push_ok && (&fetch_valid);
    assign wdata0 = fetch_valid[0] ? fetch_entry[0] : fetch_entry[1];
    assign waddr1 = wptr_q + ptr_t'(1);

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rptr_d  = rptr_q + ptr_t'(n_pop);
        wptr_d  = wptr_q + ptr_t'(n_push);
        count_d = count_q + cnt_t'(n_push) - cnt_t'(n_pop);
        if (flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    inst_fifo_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we0    (we0),
        .waddr0 (wptr_q),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (fetch_entry[1]),
        .raddr0 (rptr_q),
        .rdata0 (id_pipe[0]),
        .raddr1 (rptr_q + ptr_t'(1)),
        .rdata1 (id_pipe[1])
    );

    // ------------------------------------------------------------------
    // Protocol checks warn (the hardware recovers by clamping/dropping);
    // structural invariants are hard errors.
    // ------------------------------------------------------------------
    a_over_pop: assert property (@(posedge clk) disable iff (!resetn || flush)
        cnt_t'(n_pop_req) <= count_q)
        else $warning("inst_fifo: issue_en asked for more entries than held, pop clamped");

    a_push_not_ready: assert property (@(posedge clk) disable iff (!resetn || flush)
        (|fetch_valid) |-> fetch_ready)
        else $warning("inst_fifo: push while fetch_ready low, request dropped");

    a_count_range: assert property (@(posedge clk) disable iff (!resetn)
        count_q <= cnt_t'(DEPTH))
        else $error("inst_fifo: count out of range");

    a_ptr_count: assert property (@(posedge clk) disable iff (!resetn)
        wptr_q == ptr_t'(rptr_q + ptr_t'(count_q)))
        else $error("inst_fifo: wptr inconsistent with rptr + count");

endmodule : inst_fifo

// File: tb/tb_inst_fifo.sv
// ----------------------------------------------------------------------------
// tb_inst_fifo
//   Scoreboarded bench for inst_fifo. The driver keeps a queue model of the
//   FIFO contents; each cycle it posts the outputs the model predicts for the
//   current state, then a monitor compares them against the DUT mid-cycle.
// ----------------------------------------------------------------------------
module tb_inst_fifo;
    import inst_fifo_pkg::*;

    localparam int DEPTH = 16;

    typedef pipe_entry_t [1:0] pair_t;

    typedef struct {
        int          step;
        logic [1:0]  valid;
        pair_t       pipe;
        fifo_ctrl_t  ctrl;
        logic        ready;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic [1:0]  fetch_valid;
    pair_t       fetch_entry;
    logic        fetch_ready;
    logic [1:0]  issue_en;
    pair_t       id_pipe;
    logic [1:0]  id_valid;
    fifo_ctrl_t  fifo_ctrl;

    pipe_entry_t mdl[$];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          step  = 0;
    int          seq   = 0;

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_entry (fetch_entry),
        .fetch_ready (fetch_ready),
        .issue_en    (issue_en),
        .id_pipe     (id_pipe),
        .id_valid    (id_valid),
        .fifo_ctrl   (fifo_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int stp,
                         input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, stp, act, exp);
        end
    endtask

    function automatic pipe_entry_t mk();
        pipe_entry_t e;
        seq++;
        e.pc    = 64'h8000_0000 + 64'(seq) * 4;
        e.instr = $urandom;
        return e;
    endfunction

    function automatic pair_t mk_pair();
        pair_t p;
        p[0] = mk();
        p[1] = mk();
        return p;
    endfunction

    // One clock of stimulus: post the prediction for the current state,
    // drive inputs, then advance the model across the edge.
    task automatic cycle(input logic rst_n, input logic fl, input logic [1:0] fv,
                         input pair_t fe, input logic [1:0] ie);
        exp_t e;
        int   n;
        int   np;
        bit   rdy;
        n       = mdl.size();
        e.step  = step;
        e.valid = {n >= 2, n >= 1};
        e.pipe  = '0;
        if (n >= 1) e.pipe[0] = mdl[0];
        if (n >= 2) e.pipe[1] = mdl[1];
        e.ctrl  = '{empty: n == 0, almost_empty: n == 1,
                    full: n == DEPTH, almost_full: n == DEPTH - 1};
        e.ready = (n <= DEPTH - 2);
        exp_q.push_back(e);
        step++;

        resetn      = rst_n;
        flush       = fl;
        fetch_valid = fv;
        fetch_entry = fe;
        issue_en    = ie;
        @(posedge clk);

        if (!rst_n || fl) begin
            mdl.delete();
        end else begin
            rdy = (n <= DEPTH - 2);
            np  = ie[0] ? (ie[1] ? 2 : 1) : 0;
            if (np > n) np = n;
            repeat (np) void'(mdl.pop_front());
            if (rdy) begin
                if (fv[0]) mdl.push_back(fe[0]);
                if (fv[1]) mdl.push_back(fe[1]);
            end
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b00);
    endtask

    // Monitor: compare whatever prediction is pending at each negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("id_valid", e.step, 192'(id_valid), 192'(e.valid));
                check("fifo_ctrl", e.step, 192'(fifo_ctrl), 192'(e.ctrl));
                check("fetch_ready", e.step, 192'(fetch_ready), 192'(e.ready));
                if (e.valid[0]) check("id_pipe0", e.step, 192'(id_pipe[0]), 192'(e.pipe[0]));
                if (e.valid[1]) check("id_pipe1", e.step, 192'(id_pipe[1]), 192'(e.pipe[1]));
            end
        end
    end

    initial begin
        logic [1:0] fv;
        logic [1:0] ie;
        int         n;

        resetn      = 1'b0;
        flush       = 1'b0;
        fetch_valid = '0;
        fetch_entry = '0;
        issue_en    = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a pair becomes visible one cycle after the push.
        cycle(1'b0, 1'b0, 2'b00, '0, 2'b00);
        cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        idle();

        // Single pop to count 1, then an over-pop that clamps to empty.
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b01);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b11);
        idle();

        // Fill to 14, then 16; a push at full is dropped; pop back to 14.
        repeat (7) cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b11);
        cycle(1'b1, 1'b0, 2'b01, mk_pair(), 2'b00);
        idle();

        // Head pair straddling the wrap: rptr=15, count=4.
        cycle(1'b0, 1'b0, 2'b00, '0, 2'b00);
        repeat (8) cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        repeat (7) cycle(1'b1, 1'b0, 2'b00, '0, 2'b11);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b01);
        cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b01, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b11);
        idle();
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b11);
        idle();

        // Flush at count 9 beats a same-cycle push and pop.
        cycle(1'b1, 1'b1, 2'b00, '0, 2'b00);
        repeat (4) cycle(1'b1, 1'b0, 2'b11, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b10, mk_pair(), 2'b00);
        cycle(1'b1, 1'b1, 2'b11, mk_pair(), 2'b11);
        idle();

        // Lone slot1 push compacts to wptr; issue_en=10 pops nothing.
        cycle(1'b1, 1'b0, 2'b10, mk_pair(), 2'b00);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b10);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b10);
        cycle(1'b1, 1'b0, 2'b00, '0, 2'b01);
        idle();

        // Random legal traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            n  = mdl.size();
            fv = 2'($urandom_range(0, 3));
            ie = 2'($urandom_range(0, 3));
            if (n > DEPTH - 2) fv = 2'b00;
            if (n == 0) ie = ie & 2'b10;
            if (n == 1 && ie == 2'b11) ie = 2'b01;
            cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                  fv, mk_pair(), ie);
        end
        idle();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", step, 192'(exp_q.size()), 192'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_inst_fifo
